// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
// Pure definitions: no latency, no backpressure.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mc_condlogic.sv
// NZCV flag register plus condition evaluation; CondEx is combinational, flags update one edge after EXECUTE.
// No backpressure: flags and the held CondEx load whenever execute is high.
module mc_condlogic
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       execute,
    output logic       cond_ex,
    output logic       cond_ex_hold
);

    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // The held copy lets ALUWB gate on the pre-update flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags        <= 4'b0000;
            cond_ex_hold <= 1'b0;
        end else if (execute) begin
            cond_ex_hold <= cond_ex;
            if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM and decoder; 2-5 cycles per instruction, selects registered per state.
// No backpressure: one instruction at a time, write enables masked while reset is high.
module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        isShift
);

    state_t     state, state_nxt;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_is_pc;

    logic [2:0] dec_alu;
    logic       dec_reg_w, dec_nzw, dec_cvw, dec_mov;

    logic       src_a_pc_q, ir_write_q, pc_fetch_q, branch_q;
    logic       mem_wr_q, mem_wb_q, alu_wb_q, alu_dec_q;
    logic       cond_ex, cond_ex_hold, reg_write_int, execute;
    logic       unused_instr;

    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    assign RegSrc = {op == OP_MEM, op == OP_BR};
    assign ImmSrc = op;

    always_comb begin
        dec_alu   = ALU_ADD;
        dec_reg_w = 1'b1;
        dec_nzw   = 1'b0;
        dec_cvw   = 1'b0;
        dec_mov   = 1'b0;
        case (cmd)
            CMD_ADD: begin dec_nzw = funct[0]; dec_cvw = funct[0]; end
            CMD_SUB: begin dec_alu = ALU_SUB; dec_nzw = funct[0]; dec_cvw = funct[0]; end
            CMD_AND: begin dec_alu = ALU_AND; dec_nzw = funct[0]; end
            CMD_ORR: begin dec_alu = ALU_ORR; dec_nzw = funct[0]; end
            CMD_EOR: begin dec_alu = ALU_EOR; dec_nzw = funct[0]; end
            CMD_CMP: begin dec_alu = ALU_SUB; dec_reg_w = 1'b0; dec_nzw = 1'b1; dec_cvw = 1'b1; end
            CMD_MOV: begin dec_mov = 1'b1; dec_nzw = funct[0]; end
            default: dec_reg_w = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:   state_nxt = S_MEMADR;
                    OP_BR:    state_nxt = S_BRANCH;
                    OP_DP:    state_nxt = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_UNDEF: state_nxt = S_FETCH;
                    default:  state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_nxt = S_MEMWB;
            S_EXECUTER: state_nxt = S_ALUWB;
            S_EXECUTEI: state_nxt = S_ALUWB;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // Selects are registered against the state being entered, so they are valid from cycle start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            AdrSrc     <= 1'b0;
            src_a_pc_q <= 1'b1;
            ALUSrcB    <= SRCB_FOUR;
            ResultSrc  <= RES_ALURESULT;
            ir_write_q <= 1'b1;
            pc_fetch_q <= 1'b1;
            branch_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_wb_q   <= 1'b0;
            alu_wb_q   <= 1'b0;
            alu_dec_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            AdrSrc     <= 1'b0;
            src_a_pc_q <= 1'b0;
            ALUSrcB    <= SRCB_RM;
            ResultSrc  <= RES_ALUOUT;
            ir_write_q <= 1'b0;
            pc_fetch_q <= 1'b0;
            branch_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_wb_q   <= 1'b0;
            alu_wb_q   <= 1'b0;
            alu_dec_q  <= 1'b0;
            case (state_nxt)
                S_FETCH: begin
                    ir_write_q <= 1'b1;
                    pc_fetch_q <= 1'b1;
                    src_a_pc_q <= 1'b1;
                    ALUSrcB    <= SRCB_FOUR;
                    ResultSrc  <= RES_ALURESULT;
                end
                S_DECODE: begin
                    src_a_pc_q <= 1'b1;
                    ALUSrcB    <= SRCB_FOUR;
                    ResultSrc  <= RES_ALURESULT;
                end
                S_MEMADR: ALUSrcB <= SRCB_IMM;
                S_MEMRD:  AdrSrc  <= 1'b1;
                S_MEMWB: begin
                    ResultSrc <= RES_DATA;
                    mem_wb_q  <= 1'b1;
                end
                S_MEMWR: begin
                    AdrSrc   <= 1'b1;
                    mem_wr_q <= 1'b1;
                end
                S_EXECUTER: alu_dec_q <= 1'b1;
                S_EXECUTEI: begin
                    ALUSrcB   <= SRCB_IMM;
                    alu_dec_q <= 1'b1;
                end
                S_ALUWB: begin
                    alu_wb_q  <= 1'b1;
                    alu_dec_q <= 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcB   <= SRCB_IMM;
                    ResultSrc <= RES_ALURESULT;
                    branch_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign execute = (state == S_EXECUTER) || (state == S_EXECUTEI);

    mc_condlogic u_condlogic (
        .clk          (clk),
        .reset        (reset),
        .cond         (Instr[31:28]),
        .alu_flags    (ALUFlags),
        .flag_w       ({dec_nzw, dec_cvw}),
        .execute      (execute),
        .cond_ex      (cond_ex),
        .cond_ex_hold (cond_ex_hold)
    );

    assign reg_write_int = (mem_wb_q & cond_ex) | (alu_wb_q & dec_reg_w & cond_ex_hold);

    assign RegWrite   = ~reset & reg_write_int;
    assign MemWrite   = ~reset & mem_wr_q & cond_ex;
    assign IRWrite    = ~reset & ir_write_q;
    assign PCWrite    = ~reset & (pc_fetch_q | (branch_q & cond_ex) | (reg_write_int & rd_is_pc));
    assign ALUSrcA    = {1'b0, src_a_pc_q};
    assign ALUControl = alu_dec_q ? dec_alu : ALU_ADD;
    assign isShift    = alu_dec_q & dec_mov;

endmodule
